// File: rtl/fetch_sequencer.sv
// fetch_sequencer: fetches instruction bytes over req/ack, resolves JMP/JZ/HLT locally,
// issues plain bytes to the decoder and owns the PC load control.
module fetch_sequencer #(
    parameter logic [7:0] RESET_VEC = 8'h00,
    parameter logic [3:0] OP_JMP    = 4'hE,
    parameter logic [3:0] OP_JZ     = 4'hF,
    parameter logic [3:0] OP_HLT    = 4'hD
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] pc_addr,
    output logic       pc_load,
    output logic [7:0] pc_din,
    output logic       mem_req,
    output logic [7:0] mem_addr,
    input  logic       mem_ack,
    input  logic [7:0] mem_rdata,
    input  logic       zero_flag,
    output logic [7:0] instr_out,
    output logic       instr_valid,
    input  logic       instr_ready,
    output logic       halted
);
    typedef enum logic [2:0] {FETCH, OPERAND, REDIRECT, ISSUE, HALT} state_t;
    state_t state, state_next;
    logic [7:0] ir, target;
    logic [3:0] op;
    assign mem_addr = pc_addr;
    assign op = mem_rdata[7:4];
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= FETCH;
            ir     <= 8'h00;
            target <= 8'h00;
        end else begin
            state <= state_next;
            if (state == FETCH && mem_ack) ir <= mem_rdata;
            if (state == OPERAND && mem_ack) target <= mem_rdata;
        end
    end
    // The PC is held by reloading its own value unless a byte is consumed this cycle.
    always_comb begin
        state_next  = state;
        pc_load     = 1'b1;
        pc_din      = pc_addr;
        mem_req     = 1'b0;
        instr_valid = 1'b0;
        instr_out   = 8'h00;
        halted      = 1'b0;
        if (rst) begin
            pc_din = RESET_VEC;
        end else begin
            case (state)
                FETCH: begin
                    mem_req = 1'b1;
                    if (mem_ack) begin
                        pc_load    = 1'b0;
                        state_next = (op == OP_JMP || op == OP_JZ) ? OPERAND :
                                     (op == OP_HLT) ? HALT : ISSUE;
                    end
                end
                OPERAND: begin
                    mem_req = 1'b1;
                    if (mem_ack) begin
                        pc_load    = 1'b0;
                        state_next = (ir[7:4] == OP_JMP || zero_flag) ? REDIRECT : FETCH;
                    end
                end
                REDIRECT: begin
                    pc_din     = target;
                    state_next = FETCH;
                end
                ISSUE: begin
                    instr_valid = 1'b1;
                    instr_out   = ir;
                    if (instr_ready) state_next = FETCH;
                end
                HALT: halted = 1'b1;
                default: state_next = FETCH;
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: drives the sequencer with a PC model and byte memory; issued
// instructions are checked by a scoreboard monitor against queued expectations.
module tb_fetch_sequencer;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] pc = 8'h37;
    logic       pc_load;
    logic [7:0] pc_din;
    logic       mem_req;
    logic [7:0] mem_addr;
    logic       mem_ack;
    logic [7:0] mem_rdata;
    logic       zero_flag = 1'b0;
    logic [7:0] instr_out;
    logic       instr_valid;
    logic       instr_ready = 1'b0;
    logic       halted;
    logic       ack_en = 1'b0;
    logic [7:0] mem [256];
    int         n_cmp = 0;
    int         n_bad = 0;
    logic [15:0] exp_q [$];

    fetch_sequencer dut (
        .clk(clk), .rst(rst), .pc_addr(pc), .pc_load(pc_load), .pc_din(pc_din),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .zero_flag(zero_flag), .instr_out(instr_out), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .halted(halted)
    );

    always #5 clk = ~clk;
    always @(posedge clk) pc <= pc_load ? pc_din : pc + 8'd1;
    assign mem_ack   = mem_req & ack_en;
    assign mem_rdata = mem[mem_addr];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Each accepted instruction is paired with the PC value it should leave behind.
    always @(negedge clk) begin
        if (!rst && instr_valid && instr_ready) begin
            if (exp_q.size() == 0) chk("unexpected_issue", {16'h0, instr_out, pc}, 32'hFFFF_FFFF);
            else chk("issue_instr_pc", {16'h0, instr_out, pc}, {16'h0, exp_q.pop_front()});
        end
    end

    task automatic clear_mem;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_outputs", {pc_load, mem_req, instr_valid, halted}, 4'b1000);
        chk("rst_pc_din", pc_din, 8'h00);
        chk("rst_instr_out", instr_out, 8'h00);
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic wait_halt(input int lim, input logic [7:0] pc_exp);
        int n = 0;
        while (!halted && n < lim) begin
            @(negedge clk);
            n++;
        end
        chk("halted", halted, 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("halt_frozen", {halted, mem_req, pc}, {1'b1, 1'b0, pc_exp});
        end
    endtask

    initial begin
        // Reset and linear stream 12,34,56 then halt
        clear_mem();
        mem[8'h00] = 8'h12; mem[8'h01] = 8'h34; mem[8'h02] = 8'h56; mem[8'h03] = 8'hD0;
        #2;
        chk("rst_pc_din_vs_37", {pc, pc_din, 7'h0, pc_load}, {8'h37, 8'h00, 8'h01});
        @(posedge clk); #1;
        do_reset();
        @(negedge clk);
        chk("post_rst_fetch", {pc, mem_addr, mem_req, pc_load}, {8'h00, 8'h00, 1'b1, 1'b1});
        exp_q.push_back({8'h12, 8'h01});
        exp_q.push_back({8'h34, 8'h02});
        exp_q.push_back({8'h56, 8'h03});
        @(posedge clk); #1;
        ack_en = 1'b1; instr_ready = 1'b1;
        wait_halt(40, 8'h04);

        // Wait states then decoder backpressure
        clear_mem();
        mem[8'h00] = 8'h12; mem[8'h01] = 8'hD0;
        ack_en = 1'b0; instr_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("wait_state", {pc, mem_req, pc_load}, {8'h00, 1'b1, 1'b1});
        end
        @(posedge clk); #1;
        ack_en = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("backpressure", {instr_valid, instr_out, pc, mem_req}, {1'b1, 8'h12, 8'h01, 1'b0});
        end
        exp_q.push_back({8'h12, 8'h01});
        @(posedge clk); #1;
        instr_ready = 1'b1;
        wait_halt(20, 8'h02);

        // JMP to A5: no issue of the jump bytes, PC hits target 3 cycles after the opcode ack
        clear_mem();
        mem[8'h00] = 8'hE0; mem[8'h01] = 8'hA5; mem[8'hA5] = 8'h77; mem[8'hA6] = 8'hD0;
        exp_q.push_back({8'h77, 8'hA6});
        do_reset();
        @(negedge clk);
        chk("jmp_opcode", {pc, mem_req, pc_load}, {8'h00, 1'b1, 1'b0});
        @(negedge clk);
        chk("jmp_operand", {pc, mem_req, pc_load}, {8'h01, 1'b1, 1'b0});
        @(negedge clk);
        chk("jmp_redirect", {pc, pc_din, mem_req, pc_load}, {8'h02, 8'hA5, 1'b0, 1'b1});
        @(negedge clk);
        chk("jmp_target_fetch", {pc, mem_addr, mem_req}, {8'hA5, 8'hA5, 1'b1});
        wait_halt(20, 8'hA7);

        // JZ taken and not taken
        clear_mem();
        mem[8'h00] = 8'hE0; mem[8'h01] = 8'h10; mem[8'h10] = 8'hF0; mem[8'h11] = 8'h40;
        mem[8'h40] = 8'h21; mem[8'h41] = 8'hD0; mem[8'h12] = 8'h22; mem[8'h13] = 8'hD0;
        zero_flag = 1'b1;
        exp_q.push_back({8'h21, 8'h41});
        do_reset();
        wait_halt(30, 8'h42);
        zero_flag = 1'b0;
        exp_q.push_back({8'h22, 8'h13});
        do_reset();
        wait_halt(30, 8'h14);

        // Wrap: plain byte at FF, next fetch at 00
        clear_mem();
        mem[8'h00] = 8'hF0; mem[8'h01] = 8'hFF; mem[8'hFF] = 8'h33; mem[8'h02] = 8'hD0;
        zero_flag = 1'b1; instr_ready = 1'b0;
        do_reset();
        for (int n = 0; n < 20 && !instr_valid; n++) @(negedge clk);
        chk("wrap_issue", {instr_valid, instr_out, pc}, {1'b1, 8'h33, 8'h00});
        exp_q.push_back({8'h33, 8'h00});
        @(posedge clk); #1;
        zero_flag = 1'b0; instr_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("wrap_fetch", {mem_addr, mem_req}, {8'h00, 1'b1});
        wait_halt(30, 8'h03);

        chk("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
